// File: rtl/mpu_sequencer.sv
// mpu_sequencer: runs one matrix operation per command. It fetches A, then B, from the
// 8 x 200-bit matrix memory, holds the MPU inputs stable, waits out the MPU latency and writes the result back.
module mpu_sequencer #(
  parameter int MPU_LATENCY = 2,
  parameter int MAT_W       = 200
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             start,
  input  logic [2:0]       cmd_op,
  input  logic [2:0]       cmd_addr_a,
  input  logic [2:0]       cmd_addr_b,
  input  logic [2:0]       cmd_addr_r,
  input  logic [7:0]       cmd_scalar,
  input  logic [MAT_W-1:0] mem_rdata,
  input  logic [MAT_W-1:0] mpu_result,
  output logic [2:0]       mem_addr,
  output logic [MAT_W-1:0] mem_wdata,
  output logic             mem_wren,
  output logic [2:0]       mpu_op,
  output logic [MAT_W-1:0] mpu_matrix_a,
  output logic [MAT_W-1:0] mpu_matrix_b,
  output logic [7:0]       mpu_scalar,
  output logic [7:0]       mpu_size,
  output logic             busy,
  output logic             done,
  output logic [2:0]       state_dbg
);
  typedef enum logic [2:0] {
    IDLE = 3'd0, RD_A = 3'd1, LD_A = 3'd2, RD_B = 3'd3,
    LD_B = 3'd4, EXEC = 3'd5, WR   = 3'd6, DONE = 3'd7
  } state_t;

  localparam logic [3:0] LAT_LOAD = 4'(MPU_LATENCY - 1);

  state_t     state, state_nxt;
  logic [3:0] lat_cnt;
  logic [2:0] addr_b_q, addr_r_q;

  assign mpu_size = 8'd5;

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RD_A;
      RD_A:    state_nxt = LD_A;
      LD_A:    state_nxt = RD_B;
      RD_B:    state_nxt = LD_B;
      LD_B:    state_nxt = EXEC;
      EXEC:    if (lat_cnt == 4'd0) state_nxt = WR;
      WR:      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    state_dbg = state;
  end

  // The command is only ever latched in IDLE, so a start while busy cannot disturb it.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wren     <= 1'b0;
      mpu_op       <= '0;
      mpu_matrix_a <= '0;
      mpu_matrix_b <= '0;
      mpu_scalar   <= '0;
      addr_b_q     <= '0;
      addr_r_q     <= '0;
      lat_cnt      <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mpu_op     <= cmd_op;
          mpu_scalar <= cmd_scalar;
          addr_b_q   <= cmd_addr_b;
          addr_r_q   <= cmd_addr_r;
          mem_addr   <= cmd_addr_a;
        end
        LD_A: begin
          mpu_matrix_a <= mem_rdata;
          mem_addr     <= addr_b_q;
        end
        LD_B: begin
          mpu_matrix_b <= mem_rdata;
          lat_cnt      <= LAT_LOAD;
        end
        EXEC: begin
          if (lat_cnt == 4'd0) begin
            mem_wdata <= mpu_result;
            mem_addr  <= addr_r_q;
            mem_wren  <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        WR:      mem_wren <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mpu_sequencer.sv
// Bench for mpu_sequencer: two instances (latency 2 and 5), each with a behavioural
// memory and a delayed MPU model, checked against a per-instance reference memory.
module tb_mpu_sequencer;
  localparam int W    = 200;
  localparam int LAT0 = 2;
  localparam int LAT1 = 5;

  typedef struct packed {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [7:0]   s;
  } mpu_in_t;

  typedef struct {
    logic [2:0] op, a, b, r;
    logic [7:0] sc, fill_a, fill_b, exp_byte;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         start [2];
  logic [2:0]   op_i [2], a_i [2], b_i [2], r_i [2];
  logic [7:0]   sc_i [2];
  logic [W-1:0] rdata [2], result [2], wdata [2], ma [2], mb [2];
  logic [2:0]   maddr [2], mop [2], sdbg [2];
  logic [7:0]   msc [2], msz [2];
  logic         wren [2], busy [2], done [2];

  logic         pl_en [2];
  logic [2:0]   pl_addr [2];
  logic [W-1:0] pl_data [2];
  logic [W-1:0] mem [2][8];
  logic [W-1:0] ref_mem [2][8];
  mpu_in_t      cur [2];
  mpu_in_t      hist [2][15];

  logic [W-1:0] exp_a [2], exp_b [2];
  logic [2:0]   exp_op [2];
  logic [7:0]   exp_sc [2];

  int checks = 0, errors = 0, cyc = 0;
  int n_done [2] = '{0, 0};
  int n_wren [2] = '{0, 0};
  int bad_wren = 0, bad_hold = 0;

  mpu_sequencer #(.MPU_LATENCY(LAT0), .MAT_W(W)) dut0 (
    .Clock(clk), .Reset(rst), .start(start[0]), .cmd_op(op_i[0]),
    .cmd_addr_a(a_i[0]), .cmd_addr_b(b_i[0]), .cmd_addr_r(r_i[0]), .cmd_scalar(sc_i[0]),
    .mem_rdata(rdata[0]), .mpu_result(result[0]), .mem_addr(maddr[0]), .mem_wdata(wdata[0]),
    .mem_wren(wren[0]), .mpu_op(mop[0]), .mpu_matrix_a(ma[0]), .mpu_matrix_b(mb[0]),
    .mpu_scalar(msc[0]), .mpu_size(msz[0]), .busy(busy[0]), .done(done[0]), .state_dbg(sdbg[0]));

  mpu_sequencer #(.MPU_LATENCY(LAT1), .MAT_W(W)) dut1 (
    .Clock(clk), .Reset(rst), .start(start[1]), .cmd_op(op_i[1]),
    .cmd_addr_a(a_i[1]), .cmd_addr_b(b_i[1]), .cmd_addr_r(r_i[1]), .cmd_scalar(sc_i[1]),
    .mem_rdata(rdata[1]), .mpu_result(result[1]), .mem_addr(maddr[1]), .mem_wdata(wdata[1]),
    .mem_wren(wren[1]), .mpu_op(mop[1]), .mpu_matrix_a(ma[1]), .mpu_matrix_b(mb[1]),
    .mpu_scalar(msc[1]), .mpu_size(msz[1]), .busy(busy[1]), .done(done[1]), .state_dbg(sdbg[1]));

  function automatic int lat(int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  // MPU behaviour: per-byte add / sub / scalar multiply / xor, anything else passes A.
  function automatic logic [W-1:0] mpu_f(mpu_in_t x);
    logic [W-1:0] y;
    logic [7:0]   ab, bb;
    y = '0;
    for (int i = 0; i < 25; i++) begin
      ab = x.a[8*i +: 8];
      bb = x.b[8*i +: 8];
      case (x.op)
        3'd0:    y[8*i +: 8] = ab + bb;
        3'd1:    y[8*i +: 8] = ab - bb;
        3'd2:    y[8*i +: 8] = ab * x.s;
        3'd3:    y[8*i +: 8] = ab ^ bb;
        default: y[8*i +: 8] = ab;
      endcase
    end
    return y;
  endfunction

  function automatic logic [W-1:0] rnd_w();
    logic [W-1:0] v;
    for (int i = 0; i < 25; i++) v[8*i +: 8] = 8'($urandom());
    return v;
  endfunction

  // MPU result is valid LAT cycles after its inputs change; before that it reflects stale inputs.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      cur[k]    = '{op: mop[k], a: ma[k], b: mb[k], s: msc[k]};
      result[k] = (lat(k) == 1) ? mpu_f(cur[k]) : mpu_f(hist[k][(lat(k) >= 2) ? lat(k) - 2 : 0]);
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 2; k++) begin
      hist[k][0] <= cur[k];
      for (int i = 1; i < 15; i++) hist[k][i] <= hist[k][i-1];
      if (pl_en[k])     mem[k][pl_addr[k]] <= pl_data[k];
      else if (wren[k]) mem[k][maddr[k]]   <= wdata[k];
      rdata[k] <= mem[k][maddr[k]];
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (wren[k] && sdbg[k] != 3'd6) bad_wren++;
      if (sdbg[k] == 3'd5 && (ma[k] !== exp_a[k] || mb[k] !== exp_b[k] ||
                              mop[k] !== exp_op[k] || msc[k] !== exp_sc[k])) bad_hold++;
      if (done[k]) n_done[k]++;
      if (wren[k]) n_wren[k]++;
    end
  end

  task automatic check(input string nm, input int k, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h, expected %h", nm, k, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int k, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", nm, k, act, exp);
    end
  endtask

  task automatic chk_idle(input string nm, input int k);
    check_int({nm, "_state"}, k, int'(sdbg[k]), 0);
    check_int({nm, "_busy"},  k, int'(busy[k]), 0);
    check_int({nm, "_done"},  k, int'(done[k]), 0);
    check_int({nm, "_wren"},  k, int'(wren[k]), 0);
    check_int({nm, "_addr"},  k, int'(maddr[k]), 0);
    check_int({nm, "_op_sc"}, k, int'({mop[k], msc[k]}), 0);
    check({nm, "_data"}, k, ma[k] | mb[k] | wdata[k], '0);
  endtask

  task automatic preload(input int k, input logic [2:0] ad, input logic [W-1:0] d);
    @(negedge clk);
    pl_en[k] = 1'b1; pl_addr[k] = ad; pl_data[k] = d;
    @(negedge clk);
    pl_en[k] = 1'b0;
    ref_mem[k][ad] = d;
  endtask

  function automatic logic [W-1:0] ref_op(input int k, input logic [2:0] op, input logic [2:0] a,
                                          input logic [2:0] b, input logic [7:0] sc);
    return mpu_f('{op: op, a: ref_mem[k][a], b: ref_mem[k][b], s: sc});
  endfunction

  task automatic set_exp(input int k, input logic [2:0] op, input logic [2:0] a,
                         input logic [2:0] b, input logic [7:0] sc);
    exp_a[k] = ref_mem[k][a]; exp_b[k] = ref_mem[k][b]; exp_op[k] = op; exp_sc[k] = sc;
  endtask

  task automatic drive(input int k, input logic [2:0] op, input logic [2:0] a,
                       input logic [2:0] b, input logic [2:0] r, input logic [7:0] sc);
    start[k] = 1'b1; op_i[k] = op; a_i[k] = a; b_i[k] = b; r_i[k] = r; sc_i[k] = sc;
  endtask

  // Issue one command, report the cycle (counted from the accepting edge) in which done was seen.
  task automatic run_cmd(input int k, input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] r, input logic [7:0] sc, output int dn, output int at);
    logic [W-1:0] res;
    res = ref_op(k, op, a, b, sc);
    set_exp(k, op, a, b, sc);
    @(negedge clk);
    drive(k, op, a, b, r, sc);
    dn = -1; at = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start[k] = 1'b0;
      if (done[k]) begin dn = n; at = cyc; break; end
    end
    ref_mem[k][r] = res;
  endtask

  task automatic do_cmd(input int k, input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                        input logic [2:0] r, input logic [7:0] sc, output int at);
    int dn, w0;
    w0 = n_wren[k];
    run_cmd(k, op, a, b, r, sc, dn, at);
    check_int("latency", k, dn, 6 + lat(k));
    check("result", k, mem[k][r], ref_mem[k][r]);
    check_int("wren_cycles", k, n_wren[k] - w0, 1);
  endtask

  vec_t vt [8];

  initial begin
    int at1, at2, dn, nd, nw, bad;
    logic [W-1:0] want;
    logic [2:0] ra, rb, rr, ro;

    vt[0] = '{op: 3'd0, a: 3'd0, b: 3'd1, r: 3'd2, sc: 8'd0, fill_a: 8'h01, fill_b: 8'h02, exp_byte: 8'h03};
    vt[1] = '{op: 3'd1, a: 3'd4, b: 3'd5, r: 3'd6, sc: 8'd0, fill_a: 8'h10, fill_b: 8'h03, exp_byte: 8'h0D};
    vt[2] = '{op: 3'd2, a: 3'd7, b: 3'd0, r: 3'd1, sc: 8'd3, fill_a: 8'h05, fill_b: 8'h00, exp_byte: 8'h0F};
    vt[3] = '{op: 3'd0, a: 3'd3, b: 3'd3, r: 3'd3, sc: 8'd0, fill_a: 8'h11, fill_b: 8'h11, exp_byte: 8'h22};
    vt[4] = '{op: 3'd0, a: 3'd2, b: 3'd6, r: 3'd2, sc: 8'd0, fill_a: 8'h7F, fill_b: 8'h01, exp_byte: 8'h80};
    vt[5] = '{op: 3'd3, a: 3'd5, b: 3'd4, r: 3'd4, sc: 8'd0, fill_a: 8'hF0, fill_b: 8'h3C, exp_byte: 8'hCC};
    vt[6] = '{op: 3'd0, a: 3'd6, b: 3'd1, r: 3'd0, sc: 8'd0, fill_a: 8'hFF, fill_b: 8'h02, exp_byte: 8'h01};
    vt[7] = '{op: 3'd4, a: 3'd1, b: 3'd2, r: 3'd7, sc: 8'd9, fill_a: 8'h5A, fill_b: 8'h00, exp_byte: 8'h5A};

    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0; op_i[k] = '0; a_i[k] = '0; b_i[k] = '0; r_i[k] = '0; sc_i[k] = '0;
      pl_en[k] = 1'b0; pl_addr[k] = '0; pl_data[k] = '0;
      exp_a[k] = '0; exp_b[k] = '0; exp_op[k] = '0; exp_sc[k] = '0;
      for (int i = 0; i < 8; i++) ref_mem[k][i] = '0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk_idle("reset", k);
      check_int("size", k, int'(msz[k]), 5);
    end
    rst = 1'b0;

    // Table vectors on both latencies; includes the basic and alias cases.
    for (int k = 0; k < 2; k++) begin
      for (int v = 0; v < 8; v++) begin
        preload(k, vt[v].a, {25{vt[v].fill_a}});
        preload(k, vt[v].b, {25{vt[v].fill_b}});
        do_cmd(k, vt[v].op, vt[v].a, vt[v].b, vt[v].r, vt[v].sc, at1);
        check("table", k, mem[k][vt[v].r], {25{vt[v].exp_byte}});
      end
    end

    // start pulses in cycles 2 and 5 must be ignored.
    preload(0, 3'd0, {25{8'h01}});
    preload(0, 3'd1, {25{8'h02}});
    preload(0, 3'd7, {25{8'hEE}});
    want = ref_op(0, 3'd0, 3'd0, 3'd1, 8'd0);
    set_exp(0, 3'd0, 3'd0, 3'd1, 8'd0);
    nd = n_done[0]; dn = -1;
    @(negedge clk);
    drive(0, 3'd0, 3'd0, 3'd1, 3'd2, 8'd0);
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 2 || n == 5) drive(0, 3'd3, 3'd5, 3'd6, 3'd7, 8'h99);
      else start[0] = 1'b0;
      if (done[0] && dn < 0) dn = n;
    end
    ref_mem[0][2] = want;
    check_int("busy_start_latency", 0, dn, 8);
    check_int("busy_start_ndone", 0, n_done[0] - nd, 1);
    check("busy_start_result", 0, mem[0][2], {25{8'h03}});
    check("busy_start_r7", 0, mem[0][7], {25{8'hEE}});

    // Back-to-back, second command reads the first one's result.
    do_cmd(0, 3'd0, 3'd2, 3'd3, 3'd4, 8'd0, at1);
    do_cmd(0, 3'd1, 3'd4, 3'd2, 3'd5, 8'd0, at2);
    check_int("b2b_gap", 0, at2 - at1, 7 + LAT0);
    do_cmd(1, 3'd0, 3'd2, 3'd3, 3'd4, 8'd0, at1);
    do_cmd(1, 3'd3, 3'd4, 3'd2, 3'd5, 8'd0, at2);
    check_int("b2b_gap", 1, at2 - at1, 7 + LAT1);

    // Reset in EXEC: no write, no done.
    set_exp(0, 3'd0, 3'd0, 3'd1, 8'd0);
    nd = n_done[0]; nw = n_wren[0];
    @(negedge clk);
    drive(0, 3'd0, 3'd0, 3'd1, 3'd4, 8'd0);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      start[0] = 1'b0;
      if (n == 5) begin check_int("pre_rst_exec", 0, int'(sdbg[0]), 5); rst = 1'b1; end
      if (n == 6) begin chk_idle("rst_exec", 0); rst = 1'b0; end
    end
    check_int("rst_exec_ndone", 0, n_done[0] - nd, 0);
    check_int("rst_exec_nwren", 0, n_wren[0] - nw, 0);
    check("rst_exec_r", 0, mem[0][4], ref_mem[0][4]);

    // Reset in WR: that write lands, nothing after it.
    want = ref_op(0, 3'd0, 3'd0, 3'd1, 8'd0);
    set_exp(0, 3'd0, 3'd0, 3'd1, 8'd0);
    nd = n_done[0]; nw = n_wren[0];
    @(negedge clk);
    drive(0, 3'd0, 3'd0, 3'd1, 3'd5, 8'd0);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      start[0] = 1'b0;
      if (n == 7) begin check_int("pre_rst_wr", 0, int'(sdbg[0]), 6); rst = 1'b1; end
      if (n == 8) begin
        check_int("rst_wr_state", 0, int'(sdbg[0]), 0);
        check_int("rst_wr_wren", 0, int'(wren[0]), 0);
        rst = 1'b0;
      end
    end
    ref_mem[0][5] = want;
    check_int("rst_wr_ndone", 0, n_done[0] - nd, 0);
    check_int("rst_wr_nwren", 0, n_wren[0] - nw, 1);
    check("rst_wr_r", 0, mem[0][5], want);

    // Random commands against the reference memory.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) preload(k, 3'(i), rnd_w());
      for (int t = 0; t < 12; t++) begin
        ro = 3'($urandom_range(0, 7));
        ra = 3'($urandom_range(0, 7));
        rb = 3'($urandom_range(0, 7));
        rr = 3'($urandom_range(0, 7));
        do_cmd(k, ro, ra, rb, rr, 8'($urandom()), at1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      bad = 0;
      for (int i = 0; i < 8; i++) if (mem[k][i] !== ref_mem[k][i]) bad++;
      check_int("mem_final", k, bad, 0);
    end

    check_int("wren_outside_wr", 0, bad_wren, 0);
    check_int("operand_hold_exec", 0, bad_hold, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
